// File: rtl/fetch_unit_l5.sv
// In-order fetch stage: sequential PC generation, pipelined I-mem requests,
// in-order response buffer, commit-window throttle and squash redirect.
module fetch_unit_l5 #(
    parameter logic [31:0] p_reset_pc      = 32'h200,
    parameter int          p_buf_depth     = 4,
    parameter int          p_seq_num_bits  = 5,
    parameter int          p_max_in_flight = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [31:0]               mem_req_addr,
    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy,
    input  logic [31:0]               mem_resp_data,
    output logic                      D_val,
    input  logic                      D_rdy,
    output logic [31:0]               D_inst,
    output logic [31:0]               D_pc,
    output logic [p_seq_num_bits-1:0] D_seq_num,
    input  logic                      commit_val,
    input  logic [p_seq_num_bits-1:0] commit_seq_num,
    input  logic                      squash_val,
    input  logic [31:0]               squash_target,
    input  logic [p_seq_num_bits-1:0] squash_seq_num
);
    localparam int AW = $clog2(p_buf_depth);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;
    localparam int NB = p_seq_num_bits;
    localparam logic [SW-1:0] DEPTH   = SW'(p_buf_depth);
    localparam logic [NB-1:0] MAX_IFL = NB'(p_max_in_flight);

    logic [31:0]   pc_q, pc_d;
    // Pointers carry an extra wrap bit so full and empty are distinct.
    logic [CW-1:0] alloc_q, alloc_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [CW-1:0] head_q, head_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [NB-1:0] next_seq_q, next_seq_d;
    logic [NB-1:0] oldest_q, oldest_d;

    logic [31:0] pc_buf   [p_buf_depth];
    logic [31:0] inst_buf [p_buf_depth];

    logic [CW-1:0] used;
    logic [CW-1:0] unfilled;
    logic [SW-1:0] credit_used;
    logic [NB-1:0] in_flight;
    logic          head_filled;
    logic          req_fire;
    logic          resp_fire;
    logic          d_fire;

    assign used        = alloc_q - head_q;
    assign unfilled    = alloc_q - fill_q;
    assign credit_used = SW'(used) + SW'(drop_q);
    assign in_flight   = next_seq_q - oldest_q;
    assign head_filled = (fill_q != head_q);

    assign mem_req_val  = rst & (credit_used < DEPTH) & ~squash_val;
    assign mem_req_addr = pc_q;
    assign mem_resp_rdy = 1'b1;

    assign D_val     = head_filled & (in_flight < MAX_IFL) & ~squash_val;
    assign D_inst    = inst_buf[head_q[AW-1:0]];
    assign D_pc      = pc_buf[head_q[AW-1:0]];
    assign D_seq_num = next_seq_q;

    assign req_fire  = mem_req_val & mem_req_rdy;
    assign resp_fire = mem_resp_val;
    assign d_fire    = D_val & D_rdy;

    always_comb begin
        pc_d       = pc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        head_d     = head_q;
        drop_d     = drop_q;
        next_seq_d = next_seq_q;
        oldest_d   = oldest_q;
        if (req_fire) begin
            alloc_d = alloc_q + CW'(1);
            pc_d    = pc_q + 32'd4;
        end
        if (resp_fire) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else begin
                fill_d = fill_q + CW'(1);
            end
        end
        if (d_fire) begin
            head_d     = head_q + CW'(1);
            next_seq_d = next_seq_q + NB'(1);
        end
        if (commit_val) begin
            oldest_d = commit_seq_num + NB'(1);
        end
        // A response landing now is already counted in unfilled or drop_q.
        if (squash_val) begin
            pc_d       = squash_target;
            alloc_d    = '0;
            fill_d     = '0;
            head_d     = '0;
            next_seq_d = squash_seq_num + NB'(1);
            drop_d     = unfilled + drop_q - CW'(resp_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= p_reset_pc;
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            drop_q     <= '0;
            next_seq_q <= '0;
            oldest_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            head_q     <= head_d;
            drop_q     <= drop_d;
            next_seq_q <= next_seq_d;
            oldest_q   <= oldest_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_buf[alloc_q[AW-1:0]] <= pc_q;
        end
        if (resp_fire && drop_q == '0) begin
            inst_buf[fill_q[AW-1:0]] <= mem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit_l5.sv
// Directed bench for fetch_unit_l5 with an in-order fixed-latency
// instruction memory model.
module tb_fetch_unit_l5;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req_val;
    logic        mem_req_rdy = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_resp_val;
    logic        mem_resp_rdy;
    logic [31:0] mem_resp_data;
    logic        D_val;
    logic        D_rdy = 1'b0;
    logic [31:0] D_inst;
    logic [31:0] D_pc;
    logic [4:0]  D_seq_num;
    logic        commit_val = 1'b0;
    logic [4:0]  commit_seq_num = '0;
    logic        squash_val = 1'b0;
    logic [31:0] squash_target = '0;
    logic [4:0]  squash_seq_num = '0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    mreq_t mr;
    int    cyc = 0;
    int    mem_lat = 1;
    int    vec_cnt = 0;
    int    err_cnt = 0;

    fetch_unit_l5 dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_val   (mem_req_val),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_val  (mem_resp_val),
        .mem_resp_rdy  (mem_resp_rdy),
        .mem_resp_data (mem_resp_data),
        .D_val         (D_val),
        .D_rdy         (D_rdy),
        .D_inst        (D_inst),
        .D_pc          (D_pc),
        .D_seq_num     (D_seq_num),
        .commit_val    (commit_val),
        .commit_seq_num(commit_seq_num),
        .squash_val    (squash_val),
        .squash_target (squash_target),
        .squash_seq_num(squash_seq_num)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    // Memory: accepts when mem_req_rdy, answers in order after mem_lat cycles.
    initial begin
        mem_resp_val  = 1'b0;
        mem_resp_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                mq.delete();
                mem_resp_val = 1'b0;
            end else begin
                if (mem_req_val && mem_req_rdy) begin
                    mr.addr = mem_req_addr;
                    mr.due  = cyc + mem_lat;
                    mq.push_back(mr);
                end
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    mem_resp_val  = 1'b1;
                    mem_resp_data = inst_of(mq[0].addr);
                    void'(mq.pop_front());
                end else begin
                    mem_resp_val = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input logic drdy);
        rst         = 1'b0;
        squash_val  = 1'b0;
        commit_val  = 1'b0;
        mem_req_rdy = 1'b1;
        D_rdy       = drdy;
        mem_lat     = lat;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        #1;
        vec_cnt++;
        if (mem_req_val !== 1'b0 || D_val !== 1'b0 || mem_resp_rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_out req_val=%b d_val=%b resp_rdy=%b expected 0 0 1",
                     mem_req_val, D_val, mem_resp_rdy);
        end
        tick();
        do_reset(1, 1'b0);
        #1;
        vec_cnt++;
        if (mem_req_val !== 1'b1 || mem_req_addr !== 32'h200 || D_val !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_first req_val=%b addr=%h d_val=%b expected 1 00000200 0",
                     mem_req_val, mem_req_addr, D_val);
        end
        tick();
    endtask

    task automatic test_stream();
        logic        ev;
        logic [31:0] epc;
        logic [4:0]  eseq;
        do_reset(1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            #1;
            vec_cnt++;
            if (mem_req_val !== 1'b1 || mem_req_addr !== 32'h200 + 32'(4 * k)) begin
                err_cnt++;
                $display("FAIL stream_req k=%0d val=%b addr=%h expected 1 %h",
                         k, mem_req_val, mem_req_addr, 32'h200 + 32'(4 * k));
            end
            ev   = (k >= 2);
            epc  = 32'h200 + 32'(4 * (k - 2));
            eseq = 5'(k - 2);
            vec_cnt++;
            if (D_val !== ev || (ev && (D_pc !== epc || D_seq_num !== eseq ||
                                        D_inst !== inst_of(epc)))) begin
                err_cnt++;
                $display("FAIL stream_d k=%0d val=%b pc=%h seq=%0d inst=%h expected %b %h %0d",
                         k, D_val, D_pc, D_seq_num, D_inst, ev, epc, eseq);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic        erv;
        logic [31:0] eaddr;
        logic [31:0] epc;
        logic [4:0]  eseq;
        do_reset(1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            D_rdy = (k >= 8);
            #1;
            erv   = (k < 4) || (k == 9);
            eaddr = (k < 4) ? 32'h200 + 32'(4 * k) : 32'h210;
            vec_cnt++;
            if (mem_req_val !== erv || (erv && mem_req_addr !== eaddr)) begin
                err_cnt++;
                $display("FAIL bp_req k=%0d val=%b addr=%h expected %b %h",
                         k, mem_req_val, mem_req_addr, erv, eaddr);
            end
            if (k >= 2) begin
                epc  = (k >= 8) ? 32'h200 + 32'(4 * (k - 8)) : 32'h200;
                eseq = (k >= 8) ? 5'(k - 8) : 5'd0;
                vec_cnt++;
                if (D_val !== 1'b1 || D_pc !== epc || D_seq_num !== eseq) begin
                    err_cnt++;
                    $display("FAIL bp_d k=%0d val=%b pc=%h seq=%0d expected 1 %h %0d",
                             k, D_val, D_pc, D_seq_num, epc, eseq);
                end
            end
            tick();
        end
        D_rdy = 1'b0;
    endtask

    task automatic test_squash();
        logic [31:0] epc;
        logic [4:0]  eseq;
        do_reset(3, 1'b1);
        for (int k = 0; k < 11; k++) begin
            squash_val     = (k == 3);
            squash_target  = 32'h400;
            squash_seq_num = 5'd2;
            #1;
            if (k < 3) begin
                vec_cnt++;
                if (mem_req_val !== 1'b1 || mem_req_addr !== 32'h200 + 32'(4 * k)) begin
                    err_cnt++;
                    $display("FAIL sq_pre k=%0d val=%b addr=%h expected 1 %h",
                             k, mem_req_val, mem_req_addr, 32'h200 + 32'(4 * k));
                end
            end
            if (k == 3) begin
                vec_cnt++;
                if (mem_req_val !== 1'b0 || D_val !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL sq_cycle req_val=%b d_val=%b expected 0 0",
                             mem_req_val, D_val);
                end
            end
            if (k == 4) begin
                vec_cnt++;
                if (mem_req_val !== 1'b1 || mem_req_addr !== 32'h400) begin
                    err_cnt++;
                    $display("FAIL sq_redirect val=%b addr=%h expected 1 00000400",
                             mem_req_val, mem_req_addr);
                end
            end
            if (k >= 4 && k < 8) begin
                vec_cnt++;
                if (D_val !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL sq_drop k=%0d d_val=%b pc=%h expected 0", k, D_val, D_pc);
                end
            end
            if (k >= 8) begin
                epc  = 32'h400 + 32'(4 * (k - 8));
                eseq = 5'(3 + k - 8);
                vec_cnt++;
                if (D_val !== 1'b1 || D_pc !== epc || D_seq_num !== eseq ||
                    D_inst !== inst_of(epc)) begin
                    err_cnt++;
                    $display("FAIL sq_new k=%0d val=%b pc=%h seq=%0d inst=%h expected 1 %h %0d",
                             k, D_val, D_pc, D_seq_num, D_inst, epc, eseq);
                end
            end
            tick();
        end
        squash_val = 1'b0;
    endtask

    task automatic test_window();
        logic        ev;
        logic [4:0]  eseq;
        logic [31:0] epc;
        do_reset(1, 1'b1);
        for (int k = 0; k < 24; k++) begin
            commit_val     = (k == 21);
            commit_seq_num = 5'd0;
            #1;
            ev   = (k >= 2 && k <= 17) || (k == 22);
            eseq = (k == 22) ? 5'd16 : 5'(k - 2);
            epc  = 32'h200 + 32'(4 * int'(eseq));
            vec_cnt++;
            if (D_val !== ev || (ev && (D_pc !== epc || D_seq_num !== eseq))) begin
                err_cnt++;
                $display("FAIL window k=%0d val=%b pc=%h seq=%0d expected %b %h %0d",
                         k, D_val, D_pc, D_seq_num, ev, epc, eseq);
            end
            tick();
        end
        commit_val = 1'b0;
    endtask

    task automatic test_wrap();
        int          c_next;
        logic [4:0]  eseq;
        logic [31:0] epc;
        c_next = 0;
        do_reset(1, 1'b1);
        for (int k = 0; k < 42; k++) begin
            commit_val     = (c_next <= k - 4);
            commit_seq_num = 5'(c_next);
            #1;
            if (k >= 2) begin
                eseq = 5'(k - 2);
                epc  = 32'h200 + 32'(4 * (k - 2));
                vec_cnt++;
                if (D_val !== 1'b1 || D_pc !== epc || D_seq_num !== eseq) begin
                    err_cnt++;
                    $display("FAIL wrap k=%0d val=%b pc=%h seq=%0d expected 1 %h %0d",
                             k, D_val, D_pc, D_seq_num, epc, eseq);
                end
            end
            if (commit_val) c_next++;
            tick();
        end
        commit_val = 1'b0;
    endtask

    task automatic test_squash_commit();
        logic        ev;
        logic [4:0]  eseq;
        logic [31:0] epc;
        do_reset(2, 1'b1);
        for (int k = 0; k < 28; k++) begin
            squash_val     = (k == 4);
            squash_target  = 32'h300;
            squash_seq_num = 5'd0;
            commit_val     = (k == 4);
            commit_seq_num = 5'd0;
            #1;
            if (k == 3) begin
                vec_cnt++;
                if (D_val !== 1'b1 || D_pc !== 32'h200 || D_seq_num !== 5'd0) begin
                    err_cnt++;
                    $display("FAIL sc_pre val=%b pc=%h seq=%0d expected 1 00000200 0",
                             D_val, D_pc, D_seq_num);
                end
            end
            if (k == 4) begin
                vec_cnt++;
                if (mem_req_val !== 1'b0 || D_val !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL sc_cycle req_val=%b d_val=%b expected 0 0",
                             mem_req_val, D_val);
                end
            end
            if (k == 5) begin
                vec_cnt++;
                if (mem_req_val !== 1'b1 || mem_req_addr !== 32'h300) begin
                    err_cnt++;
                    $display("FAIL sc_redirect val=%b addr=%h expected 1 00000300",
                             mem_req_val, mem_req_addr);
                end
            end
            if (k >= 5) begin
                ev   = (k >= 8 && k <= 23);
                eseq = 5'(k - 7);
                epc  = 32'h300 + 32'(4 * (k - 8));
                vec_cnt++;
                if (D_val !== ev || (ev && (D_pc !== epc || D_seq_num !== eseq ||
                                            D_inst !== inst_of(epc)))) begin
                    err_cnt++;
                    $display("FAIL sc_after k=%0d val=%b pc=%h seq=%0d expected %b %h %0d",
                             k, D_val, D_pc, D_seq_num, ev, epc, eseq);
                end
            end
            tick();
        end
        squash_val = 1'b0;
        commit_val = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_squash();
        test_window();
        test_wrap();
        test_squash_commit();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
